// File: rtl/wb_commit_buf_pkg.sv
// Shared types for the write-back commit buffer: entry layout,
// entry width and the exception codes carried in ecode.
package wb_commit_buf_pkg;

    localparam int WB_ENTRY_WIDTH = 79;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    // Field order matches the packed in_entry bus, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
        logic        excep;
        logic [5:0]  ecode;
        logic        ertn;
        logic        refetch;
    } wb_entry_t;

    function automatic logic needs_flush(wb_entry_t e);
        return e.excep | e.ertn | e.refetch;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding commit-buffer entries.
// Ports: clk_i, rst_ni (async low), push_i/pop_i/clear_i (sync),
// data_i in, head_o = oldest entry, count_o/full_o/empty_o status.
module wb_fifo
    import wb_commit_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WB_ENTRY_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o & ~clear_i;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by plain overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/wb_commit_buf.sv
// Write-back commit buffer: queues MEM results and retires one per
// cycle to the register file, raising flushes for excep/ertn/refetch.
// Ports: clk/resetn; in_valid/in_allowin/in_entry from MEM;
// commit_stall from CSR/TLB; rf_* write port; flush_* redirect;
// debug_wb_* trace; retired_cnt and buf_count status.
module wb_commit_buf
    import wb_commit_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_allowin,
    input  logic [WB_ENTRY_WIDTH-1:0] in_entry,
    input  logic                      commit_stall,
    output logic                      rf_we,
    output logic [4:0]                rf_waddr,
    output logic [31:0]               rf_wdata,
    output logic                      flush,
    output logic                      flush_excep,
    output logic                      flush_ertn,
    output logic                      flush_refetch,
    output logic [31:0]               flush_pc,
    output logic [5:0]                flush_ecode,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_we,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [31:0]               debug_wb_rf_wdata,
    output logic [CNT_W-1:0]          retired_cnt,
    output logic [$clog2(DEPTH):0]    buf_count
);

    logic [WB_ENTRY_WIDTH-1:0] head_raw;
    wb_entry_t                 head;
    logic                      full;
    logic                      empty;
    logic                      commit;
    logic                      push;
    logic [CNT_W-1:0]          retired_cnt_q, retired_cnt_d;

    assign head = head_raw;

    // resetn gates allowin so it reads 0 during reset, not just after.
    assign in_allowin = resetn & ~full & ~flush;
    assign push       = in_valid & in_allowin;
    assign commit     = ~empty & ~commit_stall;

    assign rf_we    = commit & head.rf_we & ~head.excep;
    assign rf_waddr = head.rf_waddr;
    assign rf_wdata = head.result;

    assign flush         = commit & needs_flush(head);
    assign flush_excep   = flush & head.excep;
    assign flush_ertn    = flush & ~head.excep & head.ertn;
    assign flush_refetch = flush & ~head.excep & ~head.ertn & head.refetch;
    assign flush_pc      = flush ? head.pc : '0;
    assign flush_ecode   = flush ? head.ecode : '0;

    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign retired_cnt = retired_cnt_q;

    // Excepting heads are not retired; ertn/refetch heads are.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (commit && !head.excep) retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) retired_cnt_q <= '0;
        else         retired_cnt_q <= retired_cnt_d;
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_WIDTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (push),
        .pop_i   (commit),
        .clear_i (flush),
        .data_i  (in_entry),
        .head_o  (head_raw),
        .count_o (buf_count),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_wb_commit_buf.sv
// Self-checking bench for wb_commit_buf: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_wb_commit_buf;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] res;
        logic        excep;
        logic [5:0]  ecode;
        logic        ertn;
        logic        refetch;
    } ent_t;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_allowin;
    ent_t             drv_e = '0;
    logic             commit_stall = 1'b0;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             flush, flush_excep, flush_ertn, flush_refetch;
    logic [31:0]      flush_pc;
    logic [5:0]       flush_ecode;
    logic [31:0]      debug_wb_pc;
    logic [3:0]       debug_wb_rf_we;
    logic [4:0]       debug_wb_rf_wnum;
    logic [31:0]      debug_wb_rf_wdata;
    logic [CNT_W-1:0] retired_cnt;
    logic [CW-1:0]    buf_count;

    wb_commit_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_allowin        (in_allowin),
        .in_entry          (drv_e),
        .commit_stall      (commit_stall),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .flush             (flush),
        .flush_excep       (flush_excep),
        .flush_ertn        (flush_ertn),
        .flush_refetch     (flush_refetch),
        .flush_pc          (flush_pc),
        .flush_ecode       (flush_ecode),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retired_cnt       (retired_cnt),
        .buf_count         (buf_count)
    );

    always #5 clk = ~clk;

    ent_t             model_q[$];
    logic [CNT_W-1:0] m_cnt;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               wr_addr_q[$];
    int               wr_cyc_q[$];
    int               flush_seen;
    logic [5:0]       fl_ecode;
    logic             fl_excep, fl_ertn, fl_refetch;

    function automatic ent_t mk(input logic [31:0] pc, input logic we,
                                input logic [4:0] wa, input logic ex,
                                input logic [5:0] ec, input logic er,
                                input logic rf);
        ent_t r;
        r.pc = pc; r.we = we; r.waddr = wa; r.res = $urandom;
        r.excep = ex; r.ecode = ec; r.ertn = er; r.refetch = rf;
        return r;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_cyc_q.delete();
        flush_seen = 0;
        fl_ecode = '0; fl_excep = 0; fl_ertn = 0; fl_refetch = 0;
    endtask

    // One cycle: drive at negedge, compare against the model, then
    // advance the model to what the next posedge should produce.
    task automatic tick(input logic v, input ent_t e, input logic st,
                        output logic acc);
        ent_t h;
        logic has, cm, fl, ewe, eal;
        int   n;
        in_valid = v; drv_e = e; commit_stall = st;
        #1;
        n   = model_q.size();
        has = (n > 0);
        h   = has ? model_q[0] : '0;
        cm  = has && !st;
        fl  = cm && (h.excep || h.ertn || h.refetch);
        ewe = cm && h.we && !h.excep;
        eal = (n < DEPTH) && !fl;
        checks += 8;
        if (in_allowin !== eal) begin errors++;
            $display("FAIL allowin c%0d got %b exp %b", cyc, in_allowin, eal); end
        if (buf_count !== CW'(n)) begin errors++;
            $display("FAIL buf_count c%0d got %0d exp %0d", cyc, buf_count, n); end
        if (retired_cnt !== m_cnt) begin errors++;
            $display("FAIL retired c%0d got %0d exp %0d", cyc, retired_cnt, m_cnt); end
        if (rf_we !== ewe) begin errors++;
            $display("FAIL rf_we c%0d got %b exp %b", cyc, rf_we, ewe); end
        if (debug_wb_rf_we !== {4{ewe}}) begin errors++;
            $display("FAIL dbg_we c%0d got %h exp %h", cyc, debug_wb_rf_we, {4{ewe}}); end
        if (flush !== fl) begin errors++;
            $display("FAIL flush c%0d got %b exp %b", cyc, flush, fl); end
        if ({flush_excep, flush_ertn, flush_refetch} !==
            {fl && h.excep, fl && !h.excep && h.ertn,
             fl && !h.excep && !h.ertn && h.refetch}) begin errors++;
            $display("FAIL flush_kind c%0d got %b%b%b", cyc,
                     flush_excep, flush_ertn, flush_refetch); end
        if (has && debug_wb_pc !== h.pc) begin errors++;
            $display("FAIL dbg_pc c%0d got %h exp %h", cyc, debug_wb_pc, h.pc); end
        if (ewe) begin
            checks++;
            if ({rf_waddr, rf_wdata, debug_wb_rf_wnum, debug_wb_rf_wdata} !==
                {h.waddr, h.res, h.waddr, h.res}) begin errors++;
                $display("FAIL rf_data c%0d got %0d/%h exp %0d/%h", cyc,
                         rf_waddr, rf_wdata, h.waddr, h.res); end
        end
        if (fl) begin
            checks++;
            if ({flush_pc, flush_ecode} !== {h.pc, h.ecode}) begin errors++;
                $display("FAIL flush_pc c%0d got %h/%h exp %h/%h", cyc,
                         flush_pc, flush_ecode, h.pc, h.ecode); end
        end
        if (rf_we === 1'b1) begin
            wr_addr_q.push_back(int'(rf_waddr));
            wr_cyc_q.push_back(cyc);
        end
        if (flush === 1'b1) begin
            flush_seen++;
            fl_ecode = flush_ecode; fl_excep = flush_excep;
            fl_ertn = flush_ertn; fl_refetch = flush_refetch;
        end
        if (cm) begin
            if (!h.excep) m_cnt = m_cnt + 1'b1;
            if (fl) model_q.delete();
            else    void'(model_q.pop_front());
        end
        acc = v && eal;
        if (acc) model_q.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic st);
        logic a;
        for (int i = 0; i < n; i++) tick(1'b0, '0, st, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; in_valid = 1'b0; commit_stall = 1'b0; drv_e = '0;
        repeat (2) @(negedge clk);
        model_q.delete();
        m_cnt = '0;
        clear_logs();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_allowin, rf_we, flush, flush_excep, flush_ertn, flush_refetch,
             debug_wb_rf_we, flush_pc, flush_ecode} !== '0 ||
            buf_count !== '0 || retired_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state allow=%b we=%b fl=%b cnt=%0d ret=%0d exp 0",
                     in_allowin, rf_we, flush, buf_count, retired_cnt);
        end
        do_reset();
    endtask

    task automatic test_in_order();
        logic a;
        do_reset();
        tick(1'b1, mk(32'h1c000000, 1, 5'd1, 0, 6'h0, 0, 0), 1'b0, a);
        checks++;
        if (a !== 1'b1) begin errors++;
            $display("FAIL first_push got %b exp 1", a); end
        tick(1'b1, mk(32'h1c000004, 1, 5'd2, 0, 6'h0, 0, 0), 1'b0, a);
        tick(1'b1, mk(32'h1c000008, 1, 5'd3, 0, 6'h0, 0, 0), 1'b0, a);
        idle(2, 1'b0);
        checks += 3;
        if (wr_addr_q.size() !== 3 || wr_addr_q[0] !== 1 ||
            wr_addr_q[1] !== 2 || wr_addr_q[2] !== 3) begin errors++;
            $display("FAIL in_order writes got %0d exp 3 in order", wr_addr_q.size()); end
        else if (wr_cyc_q[1] !== wr_cyc_q[0] + 1 || wr_cyc_q[2] !== wr_cyc_q[1] + 1) begin
            errors++;
            $display("FAIL in_order spacing got %0d,%0d,%0d exp consecutive",
                     wr_cyc_q[0], wr_cyc_q[1], wr_cyc_q[2]); end
        if (retired_cnt !== 4'd3) begin errors++;
            $display("FAIL in_order retired got %0d exp 3", retired_cnt); end
        if (buf_count !== '0) begin errors++;
            $display("FAIL in_order drain got %0d exp 0", buf_count); end
    endtask

    task automatic test_full_stall();
        ent_t e[5];
        int   i = 0;
        logic a;
        do_reset();
        for (int k = 0; k < 5; k++)
            e[k] = mk(32'h2000_0000 + 32'(k * 4), 1, 5'(4 + k), 0, 6'h0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, e[i], 1'b1, a);
            if (a && i < 4) i++;
        end
        in_valid = 1'b1; drv_e = e[4]; commit_stall = 1'b1;
        #1;
        checks += 2;
        if (i !== 4 || buf_count !== CW'(4)) begin errors++;
            $display("FAIL full pushed=%0d count=%0d exp 4", i, buf_count); end
        if (in_allowin !== 1'b0) begin errors++;
            $display("FAIL full_allowin got %b exp 0", in_allowin); end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            tick(i < 5, e[i < 5 ? i : 4], 1'b0, a);
            if (a) i++;
        end
        checks += 2;
        if (i !== 5) begin errors++;
            $display("FAIL full_fifth got %0d exp 5 accepted", i); end
        if (wr_addr_q.size() !== 5 || wr_addr_q[0] !== 4 || wr_addr_q[3] !== 7 ||
            wr_addr_q[4] !== 8) begin errors++;
            $display("FAIL full_order got %0d writes exp 5 in order", wr_addr_q.size()); end
    endtask

    task automatic test_excep_flush();
        logic a;
        do_reset();
        tick(1'b1, mk(32'h3000_0000, 1, 5'd10, 0, 6'h0, 0, 0), 1'b1, a);
        tick(1'b1, mk(32'h3000_0004, 1, 5'd11, 1, 6'h0B, 0, 0), 1'b1, a);
        tick(1'b1, mk(32'h3000_0008, 1, 5'd12, 0, 6'h0, 0, 0), 1'b1, a);
        tick(1'b1, mk(32'h3000_000c, 1, 5'd13, 0, 6'h0, 0, 0), 1'b1, a);
        idle(5, 1'b0);
        checks += 3;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 10) begin errors++;
            $display("FAIL excep_writes got %0d exp 1 (r10)", wr_addr_q.size()); end
        if (flush_seen !== 1 || fl_excep !== 1'b1 || fl_ecode !== 6'h0B) begin
            errors++;
            $display("FAIL excep_flush got n=%0d ex=%b ec=%h exp 1/1/0b",
                     flush_seen, fl_excep, fl_ecode); end
        if (retired_cnt !== 4'd1 || buf_count !== '0) begin errors++;
            $display("FAIL excep_after got ret=%0d cnt=%0d exp 1/0",
                     retired_cnt, buf_count); end
    endtask

    task automatic test_ertn_refetch();
        logic a;
        do_reset();
        tick(1'b1, mk(32'h4000_0000, 0, 5'd0, 0, 6'h0, 1, 1), 1'b0, a);
        idle(3, 1'b0);
        checks += 2;
        if (flush_seen !== 1 || fl_ertn !== 1'b1 || fl_refetch !== 1'b0 ||
            fl_excep !== 1'b0) begin errors++;
            $display("FAIL ertn_prio got n=%0d er=%b rf=%b exp 1/1/0",
                     flush_seen, fl_ertn, fl_refetch); end
        if (retired_cnt !== 4'd1) begin errors++;
            $display("FAIL ertn_count got %0d exp 1", retired_cnt); end
    endtask

    task automatic test_cnt_wrap();
        logic a;
        do_reset();
        for (int k = 0; k < 17; k++)
            tick(1'b1, mk(32'h5000_0000 + 32'(k * 4), 1'($urandom), 5'($urandom),
                          0, 6'h0, 0, 0), 1'b0, a);
        idle(2, 1'b0);
        checks++;
        if (retired_cnt !== 4'd1) begin errors++;
            $display("FAIL cnt_wrap got %0d exp 1", retired_cnt); end
    endtask

    task automatic test_random();
        logic a;
        ent_t e;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            e = mk($urandom, 1'($urandom), 5'($urandom),
                   ($urandom % 16) == 0, 6'($urandom),
                   ($urandom % 16) == 0, ($urandom % 16) == 0);
            tick(($urandom % 4) != 0, e, ($urandom % 4) == 0, a);
        end
        idle(DEPTH + 2, 1'b0);
        checks++;
        if (buf_count !== '0) begin errors++;
            $display("FAIL random_drain got %0d exp 0", buf_count); end
    endtask

    task automatic test_reset_mid();
        logic a;
        do_reset();
        for (int k = 0; k < 3; k++)
            tick(1'b1, mk(32'h6000_0000 + 32'(k * 4), 1, 5'(20 + k), 0, 6'h0, 0, 0),
                 1'b1, a);
        commit_stall = 1'b0; in_valid = 1'b0; resetn = 1'b0;
        #1;
        checks++;
        if ({rf_we, flush, in_allowin, debug_wb_rf_we} !== '0 ||
            buf_count !== '0 || retired_cnt !== '0) begin errors++;
            $display("FAIL mid_reset got we=%b fl=%b allow=%b cnt=%0d exp 0",
                     rf_we, flush, in_allowin, buf_count); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rf_we !== 1'b0 || flush !== 1'b0) begin errors++;
                $display("FAIL mid_reset_pulse got we=%b fl=%b exp 0", rf_we, flush); end
        end
        @(negedge clk);
        model_q.delete();
        m_cnt = '0;
        resetn = 1'b1;
        #1;
        checks++;
        if (buf_count !== '0 || in_allowin !== 1'b1) begin errors++;
            $display("FAIL mid_reset_after got cnt=%0d allow=%b exp 0/1",
                     buf_count, in_allowin); end
        @(negedge clk);
        idle(3, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cnt = '0;
        clear_logs();
        test_reset();
        test_in_order();
        test_full_stall();
        test_excep_flush();
        test_ertn_refetch();
        test_cnt_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
